rf_wb_arbiter: RTL and testbench

Write-port controller for the 32x32 register file. After reset it runs a clear sequencer that zeroes x1..x31 through the single write port. It then shares that port between N_REQ writeback requesters (ALU, load unit, CSR, ...) using a round-robin valid/ready handshake. Its registered outputs drive the register file's write-enable, write-address and write-data inputs directly.

---
 rtl/rf_ctrl_pkg.sv | 15 +
 rtl/rf_rr_arbiter.sv | 45 ++++
 rtl/rf_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
package rf_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;
  localparam int ZERO_REG     = 0;
  localparam int LAST_REG     = NUM_REGS_DEF - 1;

endpackage

// File: rtl/rf_rr_arbiter.sv
// Combinational round-robin picker: rotate requests so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the winner back to its real index.
module rf_rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] winner,
  output logic             any_grant
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [PTR_W-1:0] pos;
  logic             found;
  logic [PTR_W:0]   sum;

  always_comb begin
    dbl   = {req, req} >> rr_ptr;
    rot   = dbl[N-1:0];
    pos   = '0;
    found = 1'b0;
    // Descending scan so the lowest set bit is the one left standing.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos   = PTR_W'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, pos};
    if (sum >= (PTR_W + 1)'(N)) begin
      sum = sum - (PTR_W + 1)'(N);
    end
    winner    = sum[PTR_W-1:0];
    any_grant = enable & found;
    grant     = '0;
    if (any_grant) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: clears x1..x(NUM_REGS-1) after reset,
// then shares the single write port among N_REQ writeback requesters.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     init_done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] X0_IDX   = ADDR_W'(ZERO_REG);
  localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(N_REQ - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                init_done_q, init_done_d;

  logic [ADDR_W-1:0]   addr_arr [N_REQ];
  logic [DATA_W-1:0]   data_arr [N_REQ];
  logic [N_REQ-1:0]    grant;
  logic [PTR_W-1:0]    winner;
  logic                any_grant;
  logic                arb_en;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A grant shown while rst is high would never be committed, so suppress it.
  assign arb_en = (state_q == ST_RUN) && !rst;

  rf_rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .enable    (arb_en),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    rr_ptr_d    = rr_ptr_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_wdata_d  = rf_wdata_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_CLEAR: begin
        rf_we_d    = 1'b1;
        rf_addr_d  = clr_idx_q;
        rf_wdata_d = '0;
        clr_idx_d  = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (any_grant) begin
          rf_addr_d  = addr_arr[winner];
          rf_wdata_d = data_arr[winner];
          // x0 writes are consumed but never reach the register file.
          rf_we_d    = (addr_arr[winner] != X0_IDX);
          rr_ptr_d   = (winner == PTR_MAX) ? '0 : winner + 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= ADDR_W'(1);
      rr_ptr_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdata_q  <= rf_wdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready = grant;
  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int N_REQ    = 3;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    rf_we;
  logic [ADDR_W-1:0]       rf_addr;
  logic [DATA_W-1:0]       rf_wdata;
  logic                    init_done;

  logic [ADDR_W-1:0] a [N_REQ];
  logic [DATA_W-1:0] d [N_REQ];

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .N_REQ    (N_REQ),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sweep counter, run flag, pointer and predicted outputs.
  bit          m_valid = 0;
  bit          m_run;
  int          m_clr;
  int          m_ptr;
  logic        e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic        e_done;

  always @(negedge clk) begin
    int w;
    logic [N_REQ-1:0] e_ready;
    if (m_valid) begin
      check("mdl_rf_we", rf_we, e_we);
      check("mdl_rf_addr", rf_addr, e_addr);
      check("mdl_rf_wdata", rf_wdata, e_data);
      check("mdl_init_done", init_done, e_done);
    end
    w = -1;
    if (!rst && m_run) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (w < 0 && req_valid[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
      end
    end
    e_ready = '0;
    if (w >= 0) e_ready[w] = 1'b1;
    if (m_valid) check("mdl_req_ready", req_ready, e_ready);
    if (rst) begin
      m_valid = 1;
      m_run   = 0;
      m_clr   = 1;
      m_ptr   = 0;
      e_we    = 0;
      e_addr  = 0;
      e_data  = 0;
      e_done  = 0;
    end else if (m_valid && !m_run) begin
      e_we   = 1;
      e_addr = m_clr[4:0];
      e_data = 0;
      if (m_clr == NUM_REGS - 1) begin
        m_run  = 1;
        e_done = 1;
      end
      m_clr++;
    end else if (m_valid) begin
      if (w >= 0) begin
        e_addr = a[w];
        e_data = d[w];
        e_we   = (a[w] != 0);
        m_ptr  = (w + 1) % N_REQ;
        $display("[TB] grant req%0d addr=%0d data=%08h", w, a[w], d[w]);
      end else begin
        e_we = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] ad, input logic [31:0] da);
    a[i] = ad;
    d[i] = da;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 3'b111;
    set_req(0, 5'd10, 32'hA0A0_0000);
    set_req(1, 5'd11, 32'hB1B1_0001);
    set_req(2, 5'd12, 32'hC2C2_0002);
    tick();
    tick();
    #2;
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;

    // Clear sweep with every requester asking.
    for (int e = 1; e < NUM_REGS; e++) begin
      check("clr_ready", req_ready, 0);
      tick();
      check("clr_we", rf_we, 1);
      check("clr_addr", rf_addr, e);
      check("clr_data", rf_wdata, 0);
      check("clr_done", init_done, (e == NUM_REGS - 1) ? 1 : 0);
    end

    // All valid from rr_ptr=0: grants rotate 0,1,2,0,1,2.
    for (int g = 0; g < 6; g++) begin
      #1;
      check("rr_ready", req_ready, 3'b001 << (g % 3));
      tick();
      check("rr_we", rf_we, 1);
      check("rr_addr", rf_addr, 10 + (g % 3));
    end

    // Single requester 0, pointer back at 0.
    req_valid = 3'b001;
    set_req(0, 5'd5, 32'hDEADBEEF);
    #1;
    check("t2_ready", req_ready, 3'b001);
    tick();
    check("t2_we", rf_we, 1);
    check("t2_addr", rf_addr, 5);
    check("t2_data", rf_wdata, 32'hDEADBEEF);

    // x0 request from requester 1 with rr_ptr=1.
    req_valid = 3'b010;
    set_req(1, 5'd0, 32'h0000_1234);
    #1;
    check("t4_ready", req_ready, 3'b010);
    tick();
    check("t4_we", rf_we, 0);
    check("t4_addr", rf_addr, 0);
    check("t4_data", rf_wdata, 32'h1234);

    // rr_ptr=2 now; a lone req0 grant moves it to 1.
    req_valid = 3'b001;
    set_req(0, 5'd3, 32'h33);
    #1;
    check("t5a_ready", req_ready, 3'b001);
    tick();

    // req0 and req2 to the same register with rr_ptr=1: req2 first.
    req_valid = 3'b101;
    set_req(0, 5'd20, 32'h0000_000A);
    set_req(2, 5'd20, 32'h0000_000B);
    #1;
    check("t5_ready_first", req_ready, 3'b100);
    tick();
    check("t5_data_first", rf_wdata, 32'hB);
    req_valid = 3'b001;
    #1;
    check("t5_ready_second", req_ready, 3'b001);
    tick();
    check("t5_addr_second", rf_addr, 20);
    check("t5_data_second", rf_wdata, 32'hA);
    req_valid = 3'b000;
    tick();
    tick();
    tick();
    check("t5_idle_we", rf_we, 0);
    check("t5_idle_data", rf_wdata, 32'hA);
    req_valid = 3'b011;
    #1;
    check("t5_ptr_held", req_ready, 3'b010);
    tick();

    // Reset pulse while req2 holds the grant.
    req_valid = 3'b100;
    set_req(2, 5'd9, 32'h99);
    #1;
    check("t6_ready_pre", req_ready, 3'b100);
    rst = 1'b1;
    #1;
    check("t6_ready_rst", req_ready, 0);
    tick();
    check("t6_we", rf_we, 0);
    check("t6_addr", rf_addr, 0);
    check("t6_done", init_done, 0);
    rst = 1'b0;
    tick();
    check("t6_restart_we", rf_we, 1);
    check("t6_restart_addr", rf_addr, 1);
    repeat (35) tick();
    check("t6_done_again", init_done, 1);
    req_valid = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
